// File: rtl/usb_fifo_outbuf.sv
// Two-entry in-order output buffer (head + skid) for the usb_app FIFO.
// Absorbs the RAM read latency so the read stream sustains one beat per clock.
module usb_fifo_outbuf #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            held
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic                  pop_ok;

    assign pop_ok = pop & (held != 2'd0);
    assign dout   = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
            held <= 2'd0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (held == 2'd0) head <= din;
                    else              skid <= din;
                    held <= held + 2'd1;
                end
                2'b01: begin
                    if (held == 2'd2) head <= skid;
                    held <= held - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; skid shifts up.
                    if (held == 2'd2) begin
                        head <= skid;
                        skid <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/usb_fifo_ctrl.sv
// Synchronous FIFO controller in front of the usb_app dual-port RAM.
// Valid/ready write stream in, first-word-fall-through read stream out.
module usb_fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] ram_cnt;
    logic                rd_pend;
    logic                pop;
    logic                issue;
    logic [1:0]          held;
    logic [2:0]          occ;
    logic [2:0]          lim;

    assign ram_cnt  = wptr - rptr;
    assign in_ready = (ram_cnt != FULL);

    assign ram_we    = in_valid & in_ready;
    assign ram_waddr = wptr[ADDR_WIDTH-1:0];
    assign ram_din   = in_data;
    assign ram_raddr = rptr[ADDR_WIDTH-1:0];

    assign out_valid = (held != 2'd0);
    assign pop       = out_valid & out_ready;

    // Issue only if the buffer has room once the in-flight word lands.
    assign occ   = {1'b0, held} + {2'b00, rd_pend};
    assign lim   = 3'd2 + {2'b00, pop};
    assign issue = (ram_cnt != '0) && (occ < lim);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (ram_we) wptr <= wptr + 1'b1;
            if (issue)  rptr <= rptr + 1'b1;
            rd_pend <= issue;
        end
    end

    assign count = (ADDR_WIDTH+2)'(ram_cnt)
                 + (ADDR_WIDTH+2)'(rd_pend)
                 + (ADDR_WIDTH+2)'(held);

    usb_fifo_outbuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outbuf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_pend),
        .din  (ram_dout),
        .pop  (pop),
        .dout (out_data),
        .held (held)
    );

    if (DEPTH < 2) begin : g_depth_chk
        $error("usb_fifo_ctrl: ADDR_WIDTH too small");
    end

endmodule
